// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: narrows stores to byte/half lanes, extends loads,
// and runs a req/ack handshake to a word-wide data memory while stalling the CPU.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLh  = 6'b100001;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLbu = 6'b100100;
    localparam logic [5:0] OpLhu = 6'b100101;
    localparam logic [5:0] OpSb  = 6'b101000;
    localparam logic [5:0] OpSh  = 6'b101001;
    localparam logic [5:0] OpSw  = 6'b101011;

    typedef enum logic [1:0] {StIdle, StReq, StErr, StDone} state_e;

    state_e            state_q, state_d;
    logic [5:0]        op_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic        legal, is_store, misaligned, accept;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    // Opcode decode and alignment check for the request being offered in IDLE
    always_comb begin
        legal      = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = wdata;
        case (opcode)
            OpLb, OpLbu: legal = 1'b1;
            OpLh, OpLhu: begin
                legal      = 1'b1;
                misaligned = addr[0];
            end
            OpLw: begin
                legal      = 1'b1;
                misaligned = |addr[1:0];
            end
            OpSb: begin
                legal    = 1'b1;
                is_store = 1'b1;
                be_d     = 4'b0001 << addr[1:0];
                wdata_d  = {4{wdata[7:0]}};
            end
            OpSh: begin
                legal      = 1'b1;
                is_store   = 1'b1;
                misaligned = addr[0];
                be_d       = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{wdata[15:0]}};
            end
            OpSw: begin
                legal      = 1'b1;
                is_store   = 1'b1;
                misaligned = |addr[1:0];
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid && legal) begin
                    accept  = 1'b1;
                    state_d = misaligned ? StErr : StReq;
                end
            end
            StReq:   if (mem_ack) state_d = StDone;
            StErr:   state_d = StIdle;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane extraction of the returned word using the latched offset
    always_comb begin
        unique case (off_q)
            2'd0: lane_byte = mem_rdata[7:0];
            2'd1: lane_byte = mem_rdata[15:8];
            2'd2: lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OpLb:    load_ext = {{24{lane_byte[7]}}, lane_byte};
            OpLbu:   load_ext = {24'd0, lane_byte};
            OpLh:    load_ext = {{16{lane_half[15]}}, lane_half};
            OpLhu:   load_ext = {16'd0, lane_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= opcode;
                off_q   <= addr[1:0];
                we_q    <= is_store;
                waddr_q <= addr[ADDR_W-1:2];
                be_q    <= be_d;
                wdata_q <= wdata_d;
            end
            if (state_q == StReq && mem_ack && !we_q) begin
                rdata_q <= load_ext;
            end
        end
    end

    // All handshake outputs decode directly from the state register
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StErr) || (state_q == StDone);
    assign misalign  = (state_q == StErr);
    assign mem_req   = (state_q == StReq);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = {waddr_q, 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: drives CPU requests, plays a memory with
// programmable wait states, and checks completion against a scoreboard queue.
module tb_mem_access_unit;

    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLh  = 6'b100001;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLbu = 6'b100100;
    localparam logic [5:0] OpLhu = 6'b100101;
    localparam logic [5:0] OpSb  = 6'b101000;
    localparam logic [5:0] OpSh  = 6'b101001;
    localparam logic [5:0] OpSw  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misalign, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic        mis;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] maddr;
        logic [31:0] rd;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .opcode    (opcode),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .misalign  (misalign),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = w >> (8 * off);
        h = w >> (8 * {off[1], 1'b0});
        case (op)
            OpLb:    return {{24{b[7]}}, b[7:0]};
            OpLbu:   return {24'd0, b[7:0]};
            OpLh:    return {{16{h[15]}}, h[15:0]};
            OpLhu:   return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] mrd, input int waits);
        exp_t e, got_e;
        int   n, reqs;
        bit   seen;
        e.we    = (op[3] == 1'b1);
        e.maddr = a & ~32'h3;
        e.mis   = ((op == OpLh || op == OpLhu || op == OpSh) && a[0]) ||
                  ((op == OpLw || op == OpSw) && a[1:0] != 2'b00);
        e.be    = 4'b1111;
        e.wd    = wd;
        if (op == OpSb) begin
            e.be = 4'b0001 << a[1:0];
            e.wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end else if (op == OpSh) begin
            e.be = a[1] ? 4'b1100 : 4'b0011;
            e.wd = {wd[15:0], wd[15:0]};
        end
        if (!e.mis && !e.we) model_rdata = model_load(op, a[1:0], mrd);
        e.rd   = model_rdata;
        e.lat  = e.mis ? 1 : waits + 2;
        e.reqs = e.mis ? 0 : waits + 1;
        sb.push_back(e);

        req_valid = 1'b1;
        opcode    = op;
        addr      = a;
        wdata     = wd;
        tick();
        n    = 1;
        reqs = 0;
        seen = 0;
        while (n <= 40 && !seen) begin
            check_val("busy_inflight", {31'd0, busy}, 32'd1);
            if (mem_req) begin
                check_val("mem_addr", mem_addr, e.maddr);
                check_val("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                check_val("mem_be", {28'd0, mem_be}, {28'd0, e.be});
                if (e.we) check_val("mem_wdata", mem_wdata, e.wd);
                mem_ack   = (reqs == waits);
                mem_rdata = (reqs == waits) ? mrd : 32'hDEAD_BEEF;
                reqs++;
            end else begin
                mem_ack = 1'b0;
            end
            if (done) begin
                seen  = 1;
                got_e = sb.pop_front();
                check_val("rdata", rdata, got_e.rd);
                check_val("misalign", {31'd0, misalign}, {31'd0, got_e.mis});
                check_val("latency", n, got_e.lat);
                check_val("req_cycles", reqs, got_e.reqs);
                req_valid = 1'b0;
            end else begin
                tick();
                n++;
            end
        end
        if (!seen) begin
            check_val("done_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        tick();
        check_val("busy_after", {31'd0, busy}, 32'd0);
        check_val("done_after", {31'd0, done}, 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_we", {31'd0, mem_we}, 32'd0);
        check_val("rst_misalign", {31'd0, misalign}, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();

        run_txn(OpLb,  32'h1003, 32'h0, 32'h80FF_1234, 0);
        run_txn(OpLbu, 32'h1003, 32'h0, 32'h80FF_1234, 0);
        run_txn(OpSh,  32'h0102, 32'h1234_ABCD, 32'h0, 0);
        run_txn(OpLh,  32'h0102, 32'h0, 32'h8001_FFFF, 0);
        run_txn(OpSw,  32'h0200, 32'h0BAD_CAFE, 32'h0, 3);
        run_txn(OpLw,  32'h0101, 32'h0, 32'h1111_1111, 0);
        run_txn(OpSh,  32'h0003, 32'h5555_6666, 32'h0, 0);
        run_txn(OpLhu, 32'h0100, 32'h0, 32'h1234_F00D, 2);
        run_txn(OpSb,  32'h0005, 32'h0000_00A5, 32'h0, 1);
        run_txn(OpLb,  32'h0002, 32'h0, 32'h0077_0000, 0);
        run_txn(OpLw,  32'h0010, 32'h0, 32'h8765_4321, 1);

        // Reset while a load waits for its ack
        req_valid = 1'b1;
        opcode    = OpLw;
        addr      = 32'h0040;
        tick();
        check_val("pre_rst_req", {31'd0, mem_req}, 32'd1);
        tick();
        #3 rst = 1'b1;
        #1;
        check_val("async_req_drop", {31'd0, mem_req}, 32'd0);
        check_val("async_busy_drop", {31'd0, busy}, 32'd0);
        check_val("async_rdata", rdata, 32'd0);
        req_valid   = 1'b0;
        model_rdata = '0;
        tick();
        rst     = 1'b0;
        mem_ack = 1'b1;
        tick();
        tick();
        check_val("stray_ack_busy", {31'd0, busy}, 32'd0);
        check_val("stray_ack_done", {31'd0, done}, 32'd0);
        mem_ack = 1'b0;
        run_txn(OpLw, 32'h0044, 32'h0, 32'hCAFE_F00D, 1);

        // Illegal opcode must never be accepted
        req_valid = 1'b1;
        opcode    = 6'b000000;
        addr      = 32'h0080;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("illegal_busy", {31'd0, busy}, 32'd0);
            check_val("illegal_req", {31'd0, mem_req}, 32'd0);
            check_val("illegal_done", {31'd0, done}, 32'd0);
        end
        req_valid = 1'b0;
        check_val("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
